// File: rtl/alarm_time_keeper_if.sv
// Avalon-MM link between the alarm time keeper (master) and the 1 Hz interval timer (slave).
// Handshake: chipselect is the request valid for exactly one cycle. The slave has zero wait
// states, so it is always ready and accepts every request in that cycle. write_n=0 marks a
// write of writedata; write_n=1 marks a read whose readdata is valid on the following cycle.
// tmr_irq is a level that stays high until status register 0 is written.
interface alarm_time_keeper_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_readdata, tmr_irq
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_readdata, tmr_irq
    );
endinterface

// File: rtl/alarm_time_keeper.sv
// Brings up the interval timer, services its 1 Hz interrupt, and keeps an HH:MM:SS
// time of day with a latched alarm.
module alarm_time_keeper #(
    parameter logic [3:0] CTRL_WORD = 4'h7,
    parameter int         RETRY_MAX = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    alarm_time_keeper_if.master        tmr,
    input  logic                       set_time,
    input  logic                       set_alarm,
    input  logic [4:0]                 set_hh,
    input  logic [5:0]                 set_mm,
    input  logic [5:0]                 set_ss,
    input  logic                       alarm_en,
    input  logic                       alarm_ack,
    output logic [4:0]                 hh,
    output logic [5:0]                 mm,
    output logic [5:0]                 ss,
    output logic                       tick,
    output logic                       alarm_ring,
    output logic                       ready,
    output logic                       timer_fault,
    output logic [2:0]                 state_dbg
);

    localparam int RW = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_WR_CTRL = 3'd1,
        S_RD_STAT = 3'd2,
        S_CHK     = 3'd3,
        S_IDLE    = 3'd4,
        S_CLR     = 3'd5,
        S_ADV     = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    state_t         state;
    logic [RW-1:0]  retry;
    logic [RW-1:0]  retry_nxt;
    logic [2:0]     addr_q;
    logic           cs_q;
    logic           wn_q;
    logic [15:0]    wd_q;
    logic [4:0]     al_hh;
    logic [5:0]     al_mm;
    logic [4:0]     adv_hh;
    logic [5:0]     adv_mm;
    logic [5:0]     adv_ss;
    logic           set_time_ok;
    logic           set_alarm_ok;
    logic           alarm_hit;
    logic           unused_rd;

    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wn_q;
    assign tmr.tmr_writedata  = wd_q;
    assign state_dbg          = state;

    // Only the RUN bit of the status register matters here.
    assign unused_rd = ^{tmr.tmr_readdata[15:2], tmr.tmr_readdata[0]};

    assign retry_nxt    = retry + RW'(1);
    assign set_time_ok  = set_time && (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
    assign set_alarm_ok = set_alarm && (set_hh <= 5'd23) && (set_mm <= 6'd59);

    // Next second of the time of day, with carries and midnight wrap.
    always_comb begin
        adv_ss = ss + 6'd1;
        adv_mm = mm;
        adv_hh = hh;
        if (ss == 6'd59) begin
            adv_ss = 6'd0;
            if (mm == 6'd59) begin
                adv_mm = 6'd0;
                adv_hh = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
            end else begin
                adv_mm = mm + 6'd1;
            end
        end
    end

    // The alarm only rings on a real advance; a set_time winning the ADV cycle suppresses it.
    assign alarm_hit = (state == S_ADV) && !set_time_ok && alarm_en &&
                       (adv_hh == al_hh) && (adv_mm == al_mm) && (adv_ss == 6'd0);

    // Control FSM with registered bus outputs: each bus access is launched on entry to its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_INIT;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= 3'd0;
            wd_q        <= 16'h0;
            retry       <= '0;
            ready       <= 1'b0;
            timer_fault <= 1'b0;
        end else begin
            cs_q   <= 1'b0;
            wn_q   <= 1'b1;
            addr_q <= 3'd0;
            wd_q   <= 16'h0;
            case (state)
                S_INIT: begin
                    state  <= S_WR_CTRL;
                    cs_q   <= 1'b1;
                    wn_q   <= 1'b0;
                    addr_q <= 3'd1;
                    wd_q   <= {12'h0, CTRL_WORD};
                end
                S_WR_CTRL: begin
                    state  <= S_RD_STAT;
                    cs_q   <= 1'b1;
                    addr_q <= 3'd0;
                end
                S_RD_STAT: begin
                    state <= S_CHK;
                end
                S_CHK: begin
                    if (tmr.tmr_readdata[1]) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        retry <= retry_nxt;
                        if (retry_nxt == RW'(RETRY_MAX)) begin
                            timer_fault <= 1'b1;
                            state       <= S_FAULT;
                        end else begin
                            state  <= S_WR_CTRL;
                            cs_q   <= 1'b1;
                            wn_q   <= 1'b0;
                            addr_q <= 3'd1;
                            wd_q   <= {12'h0, CTRL_WORD};
                        end
                    end
                end
                S_IDLE: begin
                    if (tmr.tmr_irq) begin
                        state  <= S_CLR;
                        cs_q   <= 1'b1;
                        wn_q   <= 1'b0;
                        addr_q <= 3'd0;
                        wd_q   <= 16'h0;
                    end
                end
                S_CLR: begin
                    state <= S_ADV;
                end
                S_ADV: begin
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // Time of day, alarm registers, tick pulse and latched ring flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hh         <= 5'd0;
            mm         <= 6'd0;
            ss         <= 6'd0;
            al_hh      <= 5'd0;
            al_mm      <= 6'd0;
            tick       <= 1'b0;
            alarm_ring <= 1'b0;
        end else begin
            tick <= (state == S_ADV);
            if (set_time_ok) begin
                hh <= set_hh;
                mm <= set_mm;
                ss <= set_ss;
            end else if (state == S_ADV) begin
                hh <= adv_hh;
                mm <= adv_mm;
                ss <= adv_ss;
            end
            if (set_alarm_ok) begin
                al_hh <= set_hh;
                al_mm <= set_mm;
            end
            if (alarm_hit) begin
                alarm_ring <= 1'b1;
            end else if (alarm_ack) begin
                alarm_ring <= 1'b0;
            end
        end
    end

endmodule
